interval_timer_param: RTL and testbench

//   Parametrised Avalon-MM interval timer: down-counter with software-programmable period,
//   one-shot or continuous mode, start/stop control, counter snapshot and maskable IRQ.

---
 rtl/timer_pkg.sv | 22 ++
 rtl/timer_core.sv | 47 ++++
 rtl/interval_timer_param.sv | 125 ++++++++++++
 tb/tb_interval_timer_param.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Register map and bit positions shared by the interval timer files.
package timer_pkg;

  // Word addresses of the 16-bit slave registers; 6 and 7 are reserved.
  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_PERIODL = 3'd2;
  localparam logic [2:0] ADDR_PERIODH = 3'd3;
  localparam logic [2:0] ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] ADDR_SNAPH   = 3'd5;

  // STATUS bits.
  localparam int STATUS_TO  = 0;
  localparam int STATUS_RUN = 1;

  // CONTROL bits; START and STOP are write-only strobes.
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

endpackage

// File: rtl/timer_core.sv
// Down-counter with reload, run flag and timeout detection.
// timeout is high in the cycle whose clock edge performs the terminal reload.
module timer_core #(
  parameter int                   CNT_WIDTH    = 32,
  parameter logic [CNT_WIDTH-1:0] RESET_COUNT  = '0,
  parameter bit                   RUN_AT_RESET = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 force_reload,
  input  logic                 cont,
  input  logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 running,
  output logic                 timeout
);

  // A period write or STOP in the same cycle pre-empts the terminal reload.
  assign timeout = running && (count == '0) && !stop && !force_reload;

  // Counter and run flag: period write > STOP > counting > START.
  always_ff @(posedge clk) begin
    // NOTE: all state in clocked blocks uses non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours.
    if (!reset_n) begin
      count   <= RESET_COUNT;
      running <= RUN_AT_RESET;
    end else if (force_reload) begin
      count   <= period;
      running <= 1'b0;
    end else if (stop) begin
      running <= 1'b0;
    end else if (running) begin
      if (count == '0) begin
        count   <= period;
        running <= cont;
      end else begin
        count <= count - CNT_WIDTH'(1);
      end
    end else if (start) begin
      running <= 1'b1;
    end
  end

endmodule

// File: rtl/interval_timer_param.sv
// Avalon-MM interval timer: register file, snapshot, sticky timeout, irq and read mux.
module interval_timer_param
  import timer_pkg::*;
#(
  parameter int          CNT_WIDTH      = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h7A11F,
  parameter bit          RUN_AT_RESET   = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        timeout_pulse
);

  localparam logic [CNT_WIDTH-1:0] RESET_PERIOD = DEFAULT_PERIOD[CNT_WIDTH-1:0];

  logic                 wr_en;
  logic                 rd_en;
  logic                 wr_period;
  logic                 wr_status;
  logic                 wr_control;
  logic                 wr_snap;
  logic [CNT_WIDTH-1:0] period;
  logic [CNT_WIDTH-1:0] period_next;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] snap;
  logic [31:0]          period_wide;
  logic [31:0]          period_wr;
  logic [31:0]          snap_wide;
  logic                 running;
  logic                 fire;
  logic                 to_flag;
  logic                 ito;
  logic                 cont;
  logic [15:0]          rd_mux;

  assign wr_en      = chipselect && !write_n;
  assign rd_en      = chipselect && write_n;
  assign wr_status  = wr_en && (address == ADDR_STATUS);
  assign wr_control = wr_en && (address == ADDR_CONTROL);
  assign wr_period  = wr_en && ((address == ADDR_PERIODL) || (address == ADDR_PERIODH));
  assign wr_snap    = wr_en && ((address == ADDR_SNAPL) || (address == ADDR_SNAPH));

  // Registers are viewed zero-extended to 32 bits; bits above CNT_WIDTH vanish.
  assign period_wide = 32'(period);
  assign snap_wide   = 32'(snap);

  // Merge a period half-write into the current period.
  always_comb begin
    // NOTE: default first so no path through this block leaves period_wr
    // unassigned, which would otherwise infer a latch.
    period_wr = period_wide;
    if (wr_en && (address == ADDR_PERIODL)) period_wr[15:0]  = writedata;
    if (wr_en && (address == ADDR_PERIODH)) period_wr[31:16] = writedata;
  end

  // The core reloads from the merged value in the same edge the period is written.
  assign period_next = period_wr[CNT_WIDTH-1:0];

  timer_core #(
    .CNT_WIDTH    (CNT_WIDTH),
    .RESET_COUNT  (RESET_PERIOD),
    .RUN_AT_RESET (RUN_AT_RESET)
  ) u_core (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (wr_control && writedata[CTRL_START]),
    .stop         (wr_control && writedata[CTRL_STOP]),
    .force_reload (wr_period),
    .cont         (cont),
    .period       (period_next),
    .count        (count),
    .running      (running),
    .timeout      (fire)
  );

  // Register file, snapshot and sticky timeout; a timeout beats a STATUS clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      period        <= RESET_PERIOD;
      snap          <= '0;
      to_flag       <= 1'b0;
      ito           <= 1'b0;
      cont          <= RUN_AT_RESET;
      timeout_pulse <= 1'b0;
    end else begin
      period        <= period_next;
      timeout_pulse <= fire;
      to_flag       <= fire || (to_flag && !wr_status);
      if (wr_snap) snap <= count;
      if (wr_control) begin
        ito  <= writedata[CTRL_ITO];
        cont <= writedata[CTRL_CONT];
      end
    end
  end

  // Read data select; reserved addresses read zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATUS:  rd_mux = {14'd0, running, to_flag};
      ADDR_CONTROL: rd_mux = {14'd0, cont, ito};
      ADDR_PERIODL: rd_mux = period_wide[15:0];
      ADDR_PERIODH: rd_mux = period_wide[31:16];
      ADDR_SNAPL:   rd_mux = snap_wide[15:0];
      ADDR_SNAPH:   rd_mux = snap_wide[31:16];
      default:      rd_mux = '0;
    endcase
  end

  // Registered read port, zero when not selected for a read.
  always_ff @(posedge clk) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_en ? rd_mux : 16'd0;
  end

  assign irq = to_flag && ito;

endmodule

// File: tb/tb_interval_timer_param.sv
// Self-checking bench for interval_timer_param: a 32-bit instance and an 8-bit one.
// Expected timing is derived from edge numbers: timeouts fall on edges
// start + n*(period+1); frozen counts follow from the number of elapsed edges.
module tb_interval_timer_param;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        write_n;
  logic [15:0] writedata;
  logic        cs0, cs1;
  logic [15:0] rd0, rd1;
  logic        irq0, irq1, tp0, tp1;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;   // number of rising edges so far
  int unsigned last_edge;      // edge index at which the last bus write landed
  bit          exp_to;         // model of the sticky TO flag for dut0

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  interval_timer_param #(.CNT_WIDTH(32), .DEFAULT_PERIOD(32'h7A11F), .RUN_AT_RESET(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0), .write_n(write_n),
    .writedata(writedata), .readdata(rd0), .irq(irq0), .timeout_pulse(tp0));

  interval_timer_param #(.CNT_WIDTH(8), .DEFAULT_PERIOD(32'h7A11F), .RUN_AT_RESET(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1), .write_n(write_n),
    .writedata(writedata), .readdata(rd1), .irq(irq1), .timeout_pulse(tp1));

  // Bus tasks start and end just after a falling edge.
  task automatic bus_write(input int d, input logic [2:0] a, input logic [15:0] v);
    address = a; writedata = v; write_n = 1'b0; cs0 = (d == 0); cs1 = (d == 1);
    @(negedge clk);
    last_edge = cyc;
    cs0 = 1'b0; cs1 = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input int d, input logic [2:0] a, output logic [15:0] v);
    address = a; write_n = 1'b1; cs0 = (d == 0); cs1 = (d == 1);
    @(negedge clk);
    v = (d == 1) ? rd1 : rd0;
    cs0 = 1'b0; cs1 = 1'b0;
  endtask

  task automatic idle_until(input int unsigned e);
    while (cyc < e) @(negedge clk);
  endtask

  // Watch dut0 for n cycles: pulses due every pp1 edges after s (once if one-shot).
  task automatic watch0(input int n, input int unsigned s, input int unsigned pp1, input bit cont);
    for (int i = 0; i < n; i++) begin
      int unsigned d;
      bit exp_p;
      @(negedge clk);
      d = cyc - s;
      exp_p = (d > 0) && (d % pp1 == 0) && (cont || d == pp1);
      if (exp_p) exp_to = 1'b1;
      if (tp0 !== exp_p) begin
        n_fail++; $display("FAIL pulse_timing: edge+%0d got %b expected %b (pp1=%0d)", d, tp0, exp_p, pp1);
      end
      n_checks++;
      if (irq0 !== exp_to) begin
        n_fail++; $display("FAIL irq_level: edge+%0d got %b expected %b", d, irq0, exp_to);
      end
      n_checks++;
    end
  endtask

  task automatic program0(input logic [15:0] p, input logic [15:0] ctrl, output int unsigned s);
    bus_write(0, ADDR_PERIODL, p);
    bus_write(0, ADDR_PERIODH, 16'h0000);
    bus_write(0, ADDR_STATUS, 16'h0000);
    exp_to = 1'b0;
    bus_write(0, ADDR_CONTROL, ctrl);
    s = last_edge;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    int n;
    reset_n = 1'b0; cs0 = 1'b0; cs1 = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    if (rd0 !== 16'h0 || irq0 !== 1'b0 || tp0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: rd=%h irq=%b tp=%b expected 0/0/0", rd0, irq0, tp0);
    end
    n_checks++;
    reset_n = 1'b1;
    bus_read(0, ADDR_STATUS, v);
    if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_status: got %h expected 0000", v); end
    n_checks++;
    bus_read(0, ADDR_CONTROL, v);
    if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_control: got %h expected 0000", v); end
    n_checks++;
    bus_read(0, ADDR_PERIODL, v);
    if (v !== 16'hA11F) begin n_fail++; $display("FAIL reset_periodl: got %h expected a11f", v); end
    n_checks++;
    bus_read(0, ADDR_PERIODH, v);
    if (v !== 16'h0007) begin n_fail++; $display("FAIL reset_periodh: got %h expected 0007", v); end
    n_checks++;
    bus_read(0, ADDR_SNAPL, v);
    if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_snap: got %h expected 0000", v); end
    n_checks++;
    bus_read(1, ADDR_PERIODL, v);
    if (v !== 16'h001F) begin n_fail++; $display("FAIL reset_periodl_w8: got %h expected 001f", v); end
    n_checks++;
    // Counter must sit at the default period while stopped.
    bus_write(0, ADDR_SNAPL, 16'h0);
    n = $urandom_range(3, 20);
    repeat (n) @(negedge clk);
    bus_write(0, ADDR_SNAPH, 16'h0);
    bus_read(0, ADDR_SNAPL, v);
    if (v !== 16'hA11F) begin n_fail++; $display("FAIL reset_hold_lo: got %h expected a11f", v); end
    n_checks++;
    bus_read(0, ADDR_SNAPH, v);
    if (v !== 16'h0007) begin n_fail++; $display("FAIL reset_hold_hi: got %h expected 0007", v); end
    n_checks++;
  endtask

  task automatic test_continuous(input int p);
    int unsigned s;
    program0(p[15:0], 16'h0007, s);
    watch0(3 * (p + 1), s, p + 1, 1'b1);
    if (p > 0) begin
      // Clear lands one edge after a timeout, so irq must drop, then return.
      bus_write(0, ADDR_STATUS, 16'h0000);
      exp_to = 1'b0;
      if (irq0 !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b expected 0", irq0); end
      n_checks++;
      watch0(p + 1, s, p + 1, 1'b1);
    end
  endtask

  task automatic test_oneshot(input int p);
    int unsigned s;
    logic [15:0] v;
    program0(p[15:0], 16'h0005, s);
    watch0(p + 1 + 20, s, p + 1, 1'b0);
    bus_read(0, ADDR_STATUS, v);
    if (v !== 16'h0001) begin n_fail++; $display("FAIL oneshot_status: got %h expected 0001", v); end
    n_checks++;
    bus_write(0, ADDR_SNAPL, 16'h0);
    bus_read(0, ADDR_SNAPL, v);
    if (v !== p[15:0]) begin n_fail++; $display("FAIL oneshot_reload: got %h expected %h", v, p[15:0]); end
    n_checks++;
  endtask

  task automatic test_stop_start;
    int unsigned s, t, r, q, u;
    int j, m, frozen, held;
    logic [15:0] a, b;
    program0(16'd100, 16'h0006, s);
    j = $urandom_range(5, 30);
    repeat (j) @(negedge clk);
    bus_write(0, ADDR_CONTROL, 16'h000A);
    t = last_edge;
    frozen = 100 - int'(t - s - 1);
    bus_write(0, ADDR_SNAPL, 16'h0);
    bus_read(0, ADDR_SNAPL, a);
    repeat (10) @(negedge clk);
    bus_write(0, ADDR_SNAPH, 16'h0);
    bus_read(0, ADDR_SNAPL, b);
    if (a !== 16'(frozen) || b !== 16'(frozen)) begin
      n_fail++; $display("FAIL stop_freeze: got %0d/%0d expected %0d", a, b, frozen);
    end
    n_checks++;
    bus_write(0, ADDR_CONTROL, 16'h0006);
    r = last_edge;
    m = $urandom_range(3, 20);
    repeat (m) @(negedge clk);
    bus_write(0, ADDR_SNAPL, 16'h0);
    q = last_edge;
    bus_read(0, ADDR_SNAPL, a);
    if (a !== 16'(frozen - int'(q - r - 1))) begin
      n_fail++; $display("FAIL start_resume: got %0d expected %0d", a, frozen - int'(q - r - 1));
    end
    n_checks++;
    bus_write(0, ADDR_CONTROL, 16'h000E);
    u = last_edge;
    held = frozen - int'(u - 1 - r);
    bus_write(0, ADDR_SNAPL, 16'h0);
    bus_read(0, ADDR_SNAPL, a);
    repeat (10) @(negedge clk);
    bus_write(0, ADDR_SNAPL, 16'h0);
    bus_read(0, ADDR_SNAPL, b);
    if (a !== 16'(held) || b !== 16'(held)) begin
      n_fail++; $display("FAIL start_stop_same: got %0d/%0d expected %0d", a, b, held);
    end
    n_checks++;
    bus_read(0, ADDR_STATUS, a);
    if (a[STATUS_RUN] !== 1'b0) begin n_fail++; $display("FAIL start_stop_run: got %b expected 0", a[STATUS_RUN]); end
    n_checks++;
  endtask

  task automatic test_coincident;
    int unsigned s, p, n;
    logic [15:0] v;
    p = $urandom_range(3, 8);
    program0(16'(p), 16'h0007, s);
    bus_write(0, ADDR_STATUS, 16'h0000);
    idle_until(s + p);
    bus_write(0, ADDR_STATUS, 16'h0000);   // lands on the first timeout edge
    if (tp0 !== 1'b1 || irq0 !== 1'b1) begin
      n_fail++; $display("FAIL coincide_pulse: tp=%b irq=%b expected 1/1", tp0, irq0);
    end
    n_checks++;
    bus_read(0, ADDR_STATUS, v);
    if (v !== 16'h0003) begin n_fail++; $display("FAIL coincide_status: got %h expected 0003", v); end
    n_checks++;
    n = $urandom_range(20, 200);
    idle_until(s + 3 * (p + 1) - 1);
    bus_write(0, ADDR_PERIODL, 16'(n));     // lands on a timeout edge; no pulse allowed
    if (tp0 !== 1'b0) begin n_fail++; $display("FAIL reload_no_pulse: got %b expected 0", tp0); end
    n_checks++;
    bus_write(0, ADDR_SNAPL, 16'h0);
    bus_read(0, ADDR_SNAPL, v);
    if (v !== 16'(n)) begin n_fail++; $display("FAIL reload_value: got %0d expected %0d", v, n); end
    n_checks++;
    bus_read(0, ADDR_STATUS, v);
    if (v[STATUS_RUN] !== 1'b0) begin n_fail++; $display("FAIL reload_run: got %b expected 0", v[STATUS_RUN]); end
    n_checks++;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tp0 !== 1'b0) begin n_fail++; $display("FAIL reload_quiet: cycle %0d got %b expected 0", i, tp0); end
      n_checks++;
    end
  endtask

  task automatic test_width8;
    int unsigned s, d;
    int pulses;
    logic [15:0] v;
    bus_write(1, ADDR_PERIODL, 16'h00FF);
    bus_write(1, ADDR_PERIODH, 16'h1234);
    bus_write(1, ADDR_CONTROL, 16'h0006);
    s = last_edge;
    pulses = 0;
    for (int i = 0; i < 2 * 256 + 2; i++) begin
      @(negedge clk);
      d = cyc - s;
      if (tp1 === 1'b1) pulses++;
      if (tp1 !== ((d % 256) == 0)) begin
        n_fail++; $display("FAIL w8_interval: edge+%0d got %b expected %b", d, tp1, (d % 256) == 0);
      end
      n_checks++;
    end
    if (pulses != 2) begin n_fail++; $display("FAIL w8_count: got %0d expected 2", pulses); end
    n_checks++;
    bus_read(1, ADDR_PERIODH, v);
    if (v !== 16'h0000) begin n_fail++; $display("FAIL w8_periodh: got %h expected 0000", v); end
    n_checks++;
    bus_read(1, ADDR_PERIODL, v);
    if (v !== 16'h00FF) begin n_fail++; $display("FAIL w8_periodl: got %h expected 00ff", v); end
    n_checks++;
    bus_write(0, 3'd6, 16'hFFFF);
    bus_write(1, 3'd7, 16'hFFFF);
    for (int a = 6; a < 8; a++) begin
      bus_read(0, 3'(a), v);
      if (v !== 16'h0) begin n_fail++; $display("FAIL reserved_w32: addr %0d got %h expected 0000", a, v); end
      n_checks++;
      bus_read(1, 3'(a), v);
      if (v !== 16'h0) begin n_fail++; $display("FAIL reserved_w8: addr %0d got %h expected 0000", a, v); end
      n_checks++;
    end
  endtask

  task automatic test_reset_midcount;
    int unsigned s;
    logic [15:0] v;
    program0(16'd7, 16'h0007, s);
    idle_until(s + 7);
    reset_n = 1'b0;                        // reset on the edge a timeout was due
    @(negedge clk);
    if (tp0 !== 1'b0 || irq0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: tp=%b irq=%b expected 0/0", tp0, irq0);
    end
    n_checks++;
    reset_n = 1'b1;
    bus_read(0, ADDR_STATUS, v);
    if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_mid_status: got %h expected 0000", v); end
    n_checks++;
    bus_read(0, ADDR_PERIODL, v);
    if (v !== 16'hA11F) begin n_fail++; $display("FAIL reset_mid_period: got %h expected a11f", v); end
    n_checks++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_continuous(4);
    test_continuous($urandom_range(1, 12));
    test_continuous(0);
    test_oneshot(3);
    test_oneshot($urandom_range(1, 10));
    test_stop_start();
    test_coincident();
    test_width8();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
